// File: rtl/file_copy_pkg.sv
// Shared definitions for the register-file block copy engine: default
// widths, the engine state encoding and the latched command record.
package file_copy_pkg;

  localparam int FC_ADDR_WIDTH = 8;
  localparam int FC_DATA_WIDTH = 32;
  localparam int FC_LEN_WIDTH  = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COPY   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [FC_ADDR_WIDTH-1:0] src;
    logic [FC_ADDR_WIDTH-1:0] dst;
    logic [FC_LEN_WIDTH-1:0]  len;
    logic                     verify;
  } cmd_t;

endpackage

// File: rtl/copy_addr_gen.sv
// Offset counter for the copy engine. A load picks the start offset and
// direction, each step moves one word, and the base addresses are added
// with natural wrap at the top of the file.
module copy_addr_gen
  import file_copy_pkg::*;
#(
  parameter int ADDR_WIDTH = FC_ADDR_WIDTH,
  parameter int LEN_WIDTH  = FC_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  load_down,
  input  logic [LEN_WIDTH-1:0]  load_len,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  output logic [LEN_WIDTH-1:0]  offset,
  output logic                  last,
  output logic [ADDR_WIDTH-1:0] src_addr,
  output logic [ADDR_WIDTH-1:0] dst_addr
);

  logic                 down_q;
  logic [LEN_WIDTH-1:0] len_q;

  // Offset register: load sets start point and direction, step advances until the last word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      offset <= '0;
      down_q <= 1'b0;
      len_q  <= '0;
    end else if (load) begin
      offset <= load_down ? (load_len - LEN_WIDTH'(1)) : '0;
      down_q <= load_down;
      len_q  <= load_len;
    end else if (step && !last) begin
      offset <= down_q ? (offset - LEN_WIDTH'(1)) : (offset + LEN_WIDTH'(1));
    end
  end

  // Last-word detect and base+offset addition, truncated so addresses wrap
  always_comb begin
    last     = down_q ? (offset == '0) : (offset == (len_q - LEN_WIDTH'(1)));
    src_addr = src_base + offset[ADDR_WIDTH-1:0];
    dst_addr = dst_base + offset[ADDR_WIDTH-1:0];
  end

endmodule

// File: rtl/file_copy_engine.sv
// Block copy master for a 1W/2R register file. Copies len words from a
// source region to a destination region (descending when dst > src so
// overlapping copies are safe), optionally re-reads both regions and
// reports the first differing destination address.
module file_copy_engine
  import file_copy_pkg::*;
#(
  parameter int ADDR_WIDTH = FC_ADDR_WIDTH,
  parameter int DATA_WIDTH = FC_DATA_WIDTH,
  parameter int LEN_WIDTH  = FC_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid_in,
  output logic                  cmd_ready_out,
  input  logic [ADDR_WIDTH-1:0] cmd_src_in,
  input  logic [ADDR_WIDTH-1:0] cmd_dst_in,
  input  logic [LEN_WIDTH-1:0]  cmd_len_in,
  input  logic                  cmd_verify_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  mismatch_out,
  output logic [ADDR_WIDTH-1:0] mismatch_addr_out,
  output logic [ADDR_WIDTH-1:0] write_addr_out,
  output logic                  write_out,
  output logic [DATA_WIDTH-1:0] write_data_out,
  output logic [ADDR_WIDTH-1:0] read_addr0_out,
  output logic [ADDR_WIDTH-1:0] read_addr1_out,
  output logic                  read_out,
  input  logic [DATA_WIDTH-1:0] read_data0_in,
  input  logic [DATA_WIDTH-1:0] read_data1_in,
  input  logic                  debugen_in
);

  state_t                state;
  state_t                state_next;
  cmd_t                  cmd_q;
  logic                  accept;
  logic                  gen_load;
  logic                  gen_load_down;
  logic [LEN_WIDTH-1:0]  gen_load_len;
  logic                  gen_step;
  logic [LEN_WIDTH-1:0]  gen_offset;
  logic                  gen_last;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [ADDR_WIDTH-1:0] dst_addr;

  assign accept        = (state == IDLE) && cmd_valid_in;
  assign gen_load      = accept || ((state == COPY) && gen_last && cmd_q.verify);
  assign gen_load_down = (state == IDLE) && (cmd_dst_in > cmd_src_in);
  assign gen_load_len  = (state == IDLE) ? cmd_len_in : cmd_q.len;
  assign gen_step      = (state == COPY) || (state == VERIFY);

  copy_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (gen_load),
    .load_down(gen_load_down),
    .load_len (gen_load_len),
    .step     (gen_step),
    .src_base (cmd_q.src),
    .dst_base (cmd_q.dst),
    .offset   (gen_offset),
    .last     (gen_last),
    .src_addr (src_addr),
    .dst_addr (dst_addr)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: zero-length commands skip straight to DONE, verify follows copy when asked
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid_in) state_next = (cmd_len_in != '0) ? COPY : DONE;
      COPY:    if (gen_last) state_next = cmd_q.verify ? VERIFY : DONE;
      VERIFY:  if (gen_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // File port drive: copy passes read port 0 straight to the write port, verify reads both regions
  always_comb begin
    cmd_ready_out  = (state == IDLE);
    busy_out       = (state != IDLE);
    done_out       = (state == DONE);
    write_out      = 1'b0;
    write_addr_out = '0;
    write_data_out = '0;
    read_out       = 1'b0;
    read_addr0_out = '0;
    read_addr1_out = '0;
    case (state)
      COPY: begin
        read_out       = 1'b1;
        read_addr0_out = src_addr;
        write_out      = 1'b1;
        write_addr_out = dst_addr;
        write_data_out = read_data0_in;
      end
      VERIFY: begin
        read_out       = 1'b1;
        read_addr0_out = src_addr;
        read_addr1_out = dst_addr;
      end
      default: ;
    endcase
  end

  // Command latch and sticky first-mismatch capture, cleared on every accepted command
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q             <= '0;
      mismatch_out      <= 1'b0;
      mismatch_addr_out <= '0;
    end else if (accept) begin
      cmd_q             <= '{src: cmd_src_in, dst: cmd_dst_in, len: cmd_len_in, verify: cmd_verify_in};
      mismatch_out      <= 1'b0;
      mismatch_addr_out <= '0;
    end else if ((state == VERIFY) && (read_data0_in != read_data1_in) && !mismatch_out) begin
      mismatch_out      <= 1'b1;
      mismatch_addr_out <= dst_addr;
    end
  end

`ifndef SYNTHESIS
  // Optional per-cycle trace of engine state and file port activity
  always @(posedge clk) begin
    if (debugen_in) begin
      $write("[fce] st=%0d idx=%0d wr=%b wa=%0h wd=%0h rd=%b ra0=%0h ra1=%0h\n",
             state, gen_offset, write_out, write_addr_out, write_data_out,
             read_out, read_addr0_out, read_addr1_out);
    end
  end
`endif

endmodule

// File: tb/tb_file_copy_engine.sv
// Self-checking bench for file_copy_engine. A behavioural 1W/2R register
// file sits on the engine's ports; a shadow copy of its contents predicts
// every write, which is queued when a command is issued and compared as
// the engine drives the write port.
module tb_file_copy_engine;

  localparam logic [31:0] CORRUPT_MASK = 32'h0000_FFFF;
  localparam int          CYCLE_LIMIT  = 2000;

  typedef struct {
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [8:0]  len;
    logic        verify;
    logic [31:0] seed;
    logic        corrupt;
    logic [7:0]  corruptAt;
    logic        expMis;
    logic [7:0]  expMisAddr;
  } vec_t;

  typedef struct {
    logic [7:0]  raddr;
    logic [7:0]  waddr;
    logic [31:0] wdata;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid_in = 1'b0;
  logic        cmd_ready_out;
  logic [7:0]  cmd_src_in = '0;
  logic [7:0]  cmd_dst_in = '0;
  logic [8:0]  cmd_len_in = '0;
  logic        cmd_verify_in = 1'b0;
  logic        busy_out;
  logic        done_out;
  logic        mismatch_out;
  logic [7:0]  mismatch_addr_out;
  logic [7:0]  write_addr_out;
  logic        write_out;
  logic [31:0] write_data_out;
  logic [7:0]  read_addr0_out;
  logic [7:0]  read_addr1_out;
  logic        read_out;
  logic [31:0] read_data0_in;
  logic [31:0] read_data1_in;
  logic        debugen_in = 1'b0;

  logic [31:0] mem    [256];
  logic [31:0] refMem [256];
  logic        pokeEn = 1'b0;
  logic [7:0]  pokeAddr = '0;
  logic [31:0] pokeData = '0;
  logic        corruptEn = 1'b0;
  logic [7:0]  corruptAddr = '0;

  wr_t  expQ[$];
  vec_t vecs[7];
  int   checkCount = 0;
  int   passCount = 0;

  file_copy_engine dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid_in     (cmd_valid_in),
    .cmd_ready_out    (cmd_ready_out),
    .cmd_src_in       (cmd_src_in),
    .cmd_dst_in       (cmd_dst_in),
    .cmd_len_in       (cmd_len_in),
    .cmd_verify_in    (cmd_verify_in),
    .busy_out         (busy_out),
    .done_out         (done_out),
    .mismatch_out     (mismatch_out),
    .mismatch_addr_out(mismatch_addr_out),
    .write_addr_out   (write_addr_out),
    .write_out        (write_out),
    .write_data_out   (write_data_out),
    .read_addr0_out   (read_addr0_out),
    .read_addr1_out   (read_addr1_out),
    .read_out         (read_out),
    .read_data0_in    (read_data0_in),
    .read_data1_in    (read_data1_in),
    .debugen_in       (debugen_in)
  );

  always #5 clk = ~clk;

  assign read_data0_in = mem[read_addr0_out];
  assign read_data1_in = mem[read_addr1_out];

  // Register file model: engine writes (optionally corrupted at one address) or bench preloads
  always @(posedge clk) begin
    if (write_out)
      mem[write_addr_out] <= (corruptEn && (write_addr_out == corruptAddr)) ?
                             (write_data_out ^ CORRUPT_MASK) : write_data_out;
    else if (pokeEn)
      mem[pokeAddr] <= pokeData;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    else passCount++;
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pokeEn   = 1'b1;
    pokeAddr = a;
    pokeData = d;
    refMem[a] = d;
    @(posedge clk);
    #1 pokeEn = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int   n, lat, busyCnt, verCnt, doneCyc, memErr, off;
    logic down;
    wr_t  e;
    n = int'(v.len);
    for (int i = 0; i < n; i++) poke(v.src + 8'(i), v.seed + 32'(i));
    down = (v.dst > v.src);
    expQ.delete();
    for (int k = 0; k < n; k++) begin
      off     = down ? (n - 1 - k) : k;
      e.raddr = v.src + 8'(off);
      e.waddr = v.dst + 8'(off);
      e.wdata = refMem[e.raddr];
      expQ.push_back(e);
    end
    foreach (expQ[j])
      refMem[expQ[j].waddr] = (v.corrupt && (expQ[j].waddr == v.corruptAt)) ?
                              (expQ[j].wdata ^ CORRUPT_MASK) : expQ[j].wdata;
    lat = n + (v.verify ? n : 0) + 1;
    corruptEn   = v.corrupt;
    corruptAddr = v.corruptAt;

    @(negedge clk);
    checkOutput({tag, "_ready_before"}, cmd_ready_out, 1);
    cmd_src_in    = v.src;
    cmd_dst_in    = v.dst;
    cmd_len_in    = v.len;
    cmd_verify_in = v.verify;
    cmd_valid_in  = 1'b1;
    @(posedge clk);
    #1 cmd_valid_in = 1'b0;

    busyCnt = 0;
    verCnt  = 0;
    doneCyc = 0;
    for (int cyc = 1; (cyc <= CYCLE_LIMIT) && (doneCyc == 0); cyc++) begin
      @(negedge clk);
      if (busy_out) busyCnt++;
      if (read_out && !write_out) verCnt++;
      if (write_out) begin
        if (expQ.size() == 0) begin
          checkOutput({tag, "_extra_write"}, 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput({tag, "_waddr"}, write_addr_out, e.waddr);
          checkOutput({tag, "_raddr"}, read_addr0_out, e.raddr);
          checkOutput({tag, "_wdata"}, write_data_out, e.wdata);
        end
      end
      if (done_out) begin
        doneCyc = cyc;
        checkOutput({tag, "_done_ports_idle"}, {write_out, read_out}, 0);
      end
    end
    checkOutput({tag, "_latency"}, doneCyc, lat);
    checkOutput({tag, "_busy_cycles"}, busyCnt, lat);
    checkOutput({tag, "_verify_cycles"}, verCnt, v.verify ? n : 0);
    checkOutput({tag, "_writes_left"}, expQ.size(), 0);
    checkOutput({tag, "_mismatch"}, mismatch_out, v.expMis);
    checkOutput({tag, "_mismatch_addr"}, mismatch_addr_out, v.expMis ? v.expMisAddr : 8'h00);
    memErr = 0;
    for (int k = 0; k < n; k++)
      if (mem[v.dst + 8'(k)] !== refMem[v.dst + 8'(k)]) memErr++;
    checkOutput({tag, "_dst_contents"}, memErr, 0);
    @(negedge clk);
    checkOutput({tag, "_done_one_cycle"}, done_out, 0);
    checkOutput({tag, "_ready_after"}, cmd_ready_out, 1);
    checkOutput({tag, "_mismatch_held"}, mismatch_out, v.expMis);
    corruptEn = 1'b0;
  endtask

  initial begin
    int   doneSeen;
    vec_t rv;

    vecs[0] = '{src: 8'h10, dst: 8'h40, len: 9'd4,   verify: 1'b1, seed: 32'hA0,
                corrupt: 1'b0, corruptAt: 8'h00, expMis: 1'b0, expMisAddr: 8'h00};
    vecs[1] = '{src: 8'h20, dst: 8'h22, len: 9'd4,   verify: 1'b0, seed: 32'h1,
                corrupt: 1'b0, corruptAt: 8'h00, expMis: 1'b0, expMisAddr: 8'h00};
    vecs[2] = '{src: 8'h30, dst: 8'h31, len: 9'd0,   verify: 1'b1, seed: 32'h0,
                corrupt: 1'b0, corruptAt: 8'h00, expMis: 1'b0, expMisAddr: 8'h00};
    vecs[3] = '{src: 8'hFE, dst: 8'h80, len: 9'd4,   verify: 1'b0, seed: 32'hB0,
                corrupt: 1'b0, corruptAt: 8'h00, expMis: 1'b0, expMisAddr: 8'h00};
    vecs[4] = '{src: 8'h30, dst: 8'h50, len: 9'd4,   verify: 1'b1, seed: 32'hC0,
                corrupt: 1'b1, corruptAt: 8'h52, expMis: 1'b1, expMisAddr: 8'h52};
    vecs[5] = '{src: 8'h50, dst: 8'h30, len: 9'd4,   verify: 1'b1, seed: 32'hD0,
                corrupt: 1'b0, corruptAt: 8'h00, expMis: 1'b0, expMisAddr: 8'h00};
    vecs[6] = '{src: 8'h00, dst: 8'h00, len: 9'd256, verify: 1'b1, seed: 32'h1000,
                corrupt: 1'b0, corruptAt: 8'h00, expMis: 1'b0, expMisAddr: 8'h00};

    // Reset state while held
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_busy", busy_out, 0);
    checkOutput("reset_done", done_out, 0);
    checkOutput("reset_write", write_out, 0);
    checkOutput("reset_read", read_out, 0);
    checkOutput("reset_mismatch", {mismatch_out, mismatch_addr_out}, 0);
    checkOutput("reset_addrs", {write_addr_out, read_addr0_out, read_addr1_out}, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 checkOutput("reset_release_ready", cmd_ready_out, 1);

    for (int i = 0; i < 256; i++) poke(8'(i), 32'h5A00_0000 | 32'(i));

    for (int t = 0; t < 7; t++) applyStimulus(vecs[t], $sformatf("vec%0d", t));

    // Reset dropped in the second copy cycle of a len=8 copy
    for (int i = 0; i < 8; i++) poke(8'h60 + 8'(i), 32'hE0 + 32'(i));
    @(negedge clk);
    cmd_src_in    = 8'h60;
    cmd_dst_in    = 8'h70;
    cmd_len_in    = 9'd8;
    cmd_verify_in = 1'b0;
    cmd_valid_in  = 1'b1;
    @(posedge clk);
    #1 cmd_valid_in = 1'b0;
    @(negedge clk);
    checkOutput("rst_copy_started", write_out, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_write_low", write_out, 0);
    checkOutput("rst_busy_low", busy_out, 0);
    checkOutput("rst_done_low", done_out, 0);
    doneSeen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done_out) doneSeen++;
    end
    reset = 1'b1;
    #1 checkOutput("rst_ready_after", cmd_ready_out, 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done_out) doneSeen++;
    end
    checkOutput("rst_no_done", doneSeen, 0);
    for (int i = 0; i < 256; i++) refMem[i] = mem[i];

    rv = '{src: 8'h60, dst: 8'h70, len: 9'd8, verify: 1'b1, seed: 32'hE0,
           corrupt: 1'b0, corruptAt: 8'h00, expMis: 1'b0, expMisAddr: 8'h00};
    applyStimulus(rv, "post_reset");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/file_copy_engine.md
Name: file_copy_engine

Overview:
- Initiator-side master for the 1W/2R word register file: drives its write port and both read ports.
- Performs block copies inside the file (src region -> dst region), with an optional verify pass that compares both regions through the two read ports.
- Sits between the control/command logic and the file instance.
- Hands back completion status and the first mismatching address.

Parameters:
- ADDR_WIDTH, 8, file address width; depth 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, file word width.
- LEN_WIDTH, 9, length field width; ADDR_WIDTH+1 allows a full-file copy of 256 words.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low (asserted at 0); one clock, async active-low reset.
- cmd_valid_in  in  1  command request.
- cmd_ready_out  out  1  command accepted when valid&&ready.
- cmd_src_in  in  ADDR_WIDTH  source base address.
- cmd_dst_in  in  ADDR_WIDTH  destination base address.
- cmd_len_in  in  LEN_WIDTH  word count, 0..256.
- cmd_verify_in  in  1  run the verify pass after the copy.
- busy_out  out  1  engine not IDLE.
- done_out  out  1  one-cycle completion pulse.
- mismatch_out  out  1  sticky per command: verify found a difference.
- mismatch_addr_out  out  ADDR_WIDTH  dst address of the first mismatch.
- write_addr_out  out  ADDR_WIDTH  to file write_addr_in.
- write_out  out  1  to file write_in.
- write_data_out  out  DATA_WIDTH  to file write_data_in.
- read_addr0_out  out  ADDR_WIDTH  to file read_addr0_in.
- read_addr1_out  out  ADDR_WIDTH  to file read_addr1_in.
- read_out  out  1  to file read_in.
- read_data0_in  in  DATA_WIDTH  from file read_data0_out; combinational, same cycle as address.
- read_data1_in  in  DATA_WIDTH  from file read_data1_out.
- debugen_in  in  1  enables per-cycle $write trace of state, idx and ports.

Behaviour:
- FSM states: IDLE, COPY, VERIFY, DONE.
- Reset (async, reset==0) forces:
  - state IDLE; idx 0.
  - busy_out 0, done_out 0, write_out 0, read_out 0.
  - mismatch_out 0, mismatch_addr_out 0, all address outputs 0.
  - cmd_ready_out 1 immediately after reset deasserts.
  - Mid-operation reset abandons the copy; already-written words remain in the file.
- IDLE:
  - cmd_ready_out=1.
  - On valid&&ready, latch src, dst, len, verify; clear mismatch_out and mismatch_addr_out.
  - Next state: COPY if len!=0, otherwise DONE.
- Direction:
  - dir_down=1 when dst>src (unsigned, latched at accept); copy runs from offset len-1 down to 0. Otherwise copy runs from 0 up to len-1.
  - Guarantees overlap-safe copies for non-wrapping ranges. Behaviour for ranges that wrap past address 255 is defined only by the address arithmetic below.
- Addressing: addr = base + offset, computed modulo 2**ADDR_WIDTH (wraps 255 -> 0).
- COPY, one word per cycle:
  - read_addr0_out = src+off, read_out=1.
  - write_addr_out = dst+off, write_out=1.
  - write_data_out = read_data0_in (combinational passthrough).
  - The file commits the word on the same posedge.
  - Lasts exactly len cycles.
  - Exit to VERIFY if verify is set, otherwise DONE.
- VERIFY, always ascending offset 0..len-1, one cycle per word:
  - read_addr0_out = src+off, read_addr1_out = dst+off, read_out=1, write_out=0.
  - On read_data0_in != read_data1_in while mismatch_out==0: set mismatch_out=1 and mismatch_addr_out=dst+off, registered. Later mismatches are ignored.
  - Always completes all len cycles, then DONE.
- DONE:
  - done_out=1 for exactly one cycle, busy_out=1, cmd_ready_out=0; then IDLE.
  - mismatch_out and mismatch_addr_out hold until the next accepted command.
- busy_out=1 in COPY, VERIFY and DONE.
- cmd_ready_out=1 only in IDLE; commands presented while busy are not accepted and must be held by the source.
- Latency from accept edge to done_out high: len + (verify ? len : 0) + 1 cycles.
- len=256 with src==dst: legal; rewrites every word in place.
- write_out and read_out are never 1 in IDLE or DONE.

Decomposition:
- Shared package file_copy_pkg:
  - state enum (IDLE, COPY, VERIFY, DONE).
  - ADDR_WIDTH/DATA_WIDTH/LEN_WIDTH defaults.
  - command struct {src, dst, len, verify}.
- One sub-module, copy_addr_gen:
  - Holds the offset counter; inputs load, up/down, step.
  - Outputs offset and a last flag.
  - Adds the bases with wrap.

Test Plan:
- Preload words 0x10..0x13 = A0,A1,A2,A3; command src=0x10, dst=0x40, len=4, verify=1 -> 4 write cycles to 0x40..0x43 with A0..A3, then 4 verify cycles, done_out 9 cycles after accept, mismatch_out=0.
- Overlap, src=0x20, dst=0x22, len=4, initial 0x20..0x23 = 1,2,3,4 -> writes issued at descending addresses 0x25,0x24,0x23,0x22; final 0x22..0x25 = 1,2,3,4.
- len=0 -> no write_out, done_out one cycle after accept, busy_out high exactly one cycle.
- Wrap, src=0xFE, dst=0x80, len=4 -> reads from 0xFE, 0xFF, 0x00, 0x01; writes to 0x80..0x83.
- Verify-only mismatch: copy into 0x50..0x53; bench then forces write_in data corruption at 0x52 during copy by overriding → mismatch_out=1, mismatch_addr_out=0x52, done still pulses.
- Drop reset to 0 in the 2nd COPY cycle of a len=8 copy -> write_out low asynchronously, busy_out 0, done_out never pulses; after release cmd_ready_out=1 and a new command runs correctly.
